mem_port_arbiter: RTL

- Shares the single external memory port between the Fetch stage (instruction reads) and the Memory stage (data loads and stores).
- Sits between the core's F/M stages and the external memory interface; one transaction is outstanding at a time.
- Returns read data to the granted requester with a one-cycle valid pulse and drives per-stage stall signals.
- Data accesses have priority over fetches. A streak counter prevents fetch starvation.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and external-memory signals around mem_port_arbiter.
// Handshakes: each *_Req is held until its one-cycle *_Valid pulse; External_MemEn is held until the cycle External_MemReady=1.
interface mem_port_arbiter_if #(parameter int XLEN = 32);
  localparam int NB = XLEN / 8;

  logic            Instr_Req;
  logic [XLEN-1:0] Instr_Adr;
  logic            Instr_Valid;
  logic [XLEN-1:0] Instr_Data;

  logic            Data_Req;
  logic            Data_WriteEn;
  logic [NB-1:0]   Data_WriteByteEn;
  logic [XLEN-1:0] Data_Adr;
  logic [XLEN-1:0] Data_WriteData;
  logic            Data_Valid;
  logic [XLEN-1:0] Data_ReadData;

  logic            Stall_F;
  logic            Stall_M;

  logic            External_MemEn;
  logic            External_MemWriteEn;
  logic [NB-1:0]   External_MemWriteByteEn;
  logic [XLEN-1:0] External_MemAdr;
  logic [XLEN-1:0] External_MemWriteData;
  logic            External_MemReady;
  logic            External_MemRespValid;
  logic [XLEN-1:0] External_MemReadData;

  modport slave (
    input  Instr_Req, Instr_Adr,
    input  Data_Req, Data_WriteEn, Data_WriteByteEn, Data_Adr, Data_WriteData,
    input  External_MemReady, External_MemRespValid, External_MemReadData,
    output Instr_Valid, Instr_Data, Data_Valid, Data_ReadData, Stall_F, Stall_M,
    output External_MemEn, External_MemWriteEn, External_MemWriteByteEn,
    output External_MemAdr, External_MemWriteData
  );

  modport master (
    output Instr_Req, Instr_Adr,
    output Data_Req, Data_WriteEn, Data_WriteByteEn, Data_Adr, Data_WriteData,
    output External_MemReady, External_MemRespValid, External_MemReadData,
    input  Instr_Valid, Instr_Data, Data_Valid, Data_ReadData, Stall_F, Stall_M,
    input  External_MemEn, External_MemWriteEn, External_MemWriteByteEn,
    input  External_MemAdr, External_MemWriteData
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and data requesters, one access in flight.
// Data has priority; a streak counter forces a waiting fetch through after MAX_DATA_STREAK data grants.
module mem_port_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_DATA_STREAK = 4,
  localparam int SW             = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]    state_dbg,
  output logic [SW-1:0] streak_dbg
);
  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   streak;
  logic            owner_data;
  logic [XLEN-1:0] adr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic [NB-1:0]   ben_q;
  logic            instr_valid_q, data_valid_q;
  logic [XLEN-1:0] instr_data_q, data_rdata_q;
  logic            grant_data, grant_instr;

  always_comb begin
    grant_data  = 1'b0;
    grant_instr = 1'b0;
    if (bus.Data_Req && bus.Instr_Req) begin
      if ((MAX_DATA_STREAK != 0) && (streak == SW'(MAX_DATA_STREAK))) grant_instr = 1'b1;
      else                                                             grant_data  = 1'b1;
    end else begin
      grant_data  = bus.Data_Req;
      grant_instr = bus.Instr_Req;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Instr_Req || bus.Data_Req) state_nxt = ISSUE;
      ISSUE:   if (bus.External_MemReady)         state_nxt = WAIT;
      WAIT:    if (bus.External_MemRespValid)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      streak        <= '0;
      owner_data    <= 1'b0;
      adr_q         <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      ben_q         <= '0;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      instr_data_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      state         <= state_nxt;
      instr_valid_q <= 1'b0;
      data_valid_q  <= 1'b0;
      if (state == IDLE && (grant_data || grant_instr)) begin
        owner_data <= grant_data;
        adr_q      <= (grant_data ? bus.Data_Adr : bus.Instr_Adr) & ~XLEN'(NB - 1);
        we_q       <= grant_data & bus.Data_WriteEn;
        ben_q      <= (grant_data && bus.Data_WriteEn) ? bus.Data_WriteByteEn : '0;
        wdata_q    <= (grant_data && bus.Data_WriteEn) ? bus.Data_WriteData : '0;
        // Streak only counts data grants that actually made a fetch wait.
        if (grant_instr || !bus.Instr_Req)           streak <= '0;
        else if (streak != SW'(MAX_DATA_STREAK))     streak <= streak + 1'b1;
      end
      if (state == WAIT && bus.External_MemRespValid) begin
        if (owner_data) begin
          data_valid_q <= 1'b1;
          data_rdata_q <= we_q ? '0 : bus.External_MemReadData;
        end else begin
          instr_valid_q <= 1'b1;
          instr_data_q  <= bus.External_MemReadData;
        end
      end
    end
  end

  assign bus.External_MemEn          = (state == ISSUE);
  assign bus.External_MemWriteEn     = we_q;
  assign bus.External_MemWriteByteEn = ben_q;
  assign bus.External_MemAdr         = adr_q;
  assign bus.External_MemWriteData   = wdata_q;

  assign bus.Instr_Valid   = instr_valid_q;
  assign bus.Instr_Data    = instr_data_q;
  assign bus.Data_Valid    = data_valid_q;
  assign bus.Data_ReadData = data_rdata_q;
  assign bus.Stall_F       = bus.Instr_Req & ~instr_valid_q;
  assign bus.Stall_M       = bus.Data_Req & ~data_valid_q;

  assign state_dbg  = state;
  assign streak_dbg = streak;
endmodule
